// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the machine-level interrupt arbiter: FSM encoding
// and the standard machine-mode cause codes.
package irq_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;
    localparam arb_state_t ST_END   = 2'd3;

    localparam int CAUSE_MSI          = 3;
    localparam int CAUSE_MTI          = 7;
    localparam int CAUSE_MEI          = 11;
    localparam int CAUSE_BASE_DEFAULT = 16;

    // Width of a source index; a single source still needs one bit.
    function automatic int id_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/irq_arbiter_pick.sv
// Combinational winner select: lowest set candidate (fixed) or first set
// candidate at/above ptr with wrap-around (round-robin).
module irq_pick
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int RR   = 0,
    parameter int ID_W = id_width(NSRC)
) (
    input  logic [NSRC-1:0] cand,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    logic [ID_W-1:0] eff_ptr;
    logic [NSRC-1:0] upper_mask;
    logic [NSRC-1:0] upper_cand;

    function automatic logic [ID_W-1:0] lowest_set(input logic [NSRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    // Fixed priority is round-robin with the pointer pinned at zero.
    assign eff_ptr = (RR != 0) ? ptr : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_mask
            assign upper_mask[gi] = (gi >= int'(eff_ptr));
        end
    endgenerate

    assign upper_cand = cand & upper_mask;
    assign valid      = |cand;
    assign id         = (|upper_cand) ? lowest_set(upper_cand) : lowest_set(cand);

endmodule

// File: rtl/irq_arbiter.sv
// Machine-level interrupt arbiter with interrupt/int_reply handshake.
// Optional reply watchdog enabled by defining IRQ_ARB_TIMEOUT_EN.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC        = 4,
    parameter int CODE_W      = 5,
    parameter int BASE_CODE   = CAUSE_BASE_DEFAULT,
    parameter int RR          = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_in,
    input  logic [NSRC-1:0]   irq_en,
    input  logic              gie,
    output logic [NSRC-1:0]   irq_ack,
    output logic              interrupt,
    input  logic              int_reply,
    output logic [CODE_W-1:0] cause_code,
    output logic [NSRC-1:0]   pending,
    output logic              lost
);

    localparam int ID_W = id_width(NSRC);

    arb_state_t      state_reg;
    logic [ID_W-1:0] id_reg;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_wrap;
    logic [ID_W-1:0] pick_id;
    logic            pick_valid;
    logic            int_reply_q;
    logic            timeout_hit;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] grant_vec;

    assign cand = pending & irq_en;

    irq_pick #(
        .NSRC (NSRC),
        .RR   (RR),
        .ID_W (ID_W)
    ) u_pick (
        .cand  (cand),
        .ptr   (ptr_reg),
        .id    (pick_id),
        .valid (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_grant
            assign grant_vec[gi] = (int'(id_reg) == gi);
        end
    endgenerate

    assign ptr_wrap = (int'(id_reg) == NSRC - 1) ? '0 : id_reg + 1'b1;

`ifdef IRQ_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] wait_cnt_reg;

    assign timeout_hit = (wait_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    // Counter restarts on every WAIT entry; lost stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            lost         <= 1'b0;
        end else begin
            if (state_reg != ST_WAIT) begin
                wait_cnt_reg <= '0;
            end else if (!timeout_hit) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (state_reg == ST_WAIT && !int_reply_q && timeout_hit) begin
                lost <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign lost        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            id_reg      <= '0;
            ptr_reg     <= '0;
            pending     <= '0;
            int_reply_q <= 1'b0;
            interrupt   <= 1'b0;
            irq_ack     <= '0;
            cause_code  <= '0;
        end else begin
            pending     <= irq_in;
            int_reply_q <= int_reply;
            case (state_reg)
                ST_IDLE: begin
                    // A still-high reply from the previous grant blocks a new one.
                    if (gie && pick_valid && !int_reply_q) begin
                        id_reg    <= pick_id;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    interrupt  <= 1'b1;
                    irq_ack    <= grant_vec;
                    cause_code <= CODE_W'(BASE_CODE + int'(id_reg));
                    if (RR != 0) begin
                        ptr_reg <= ptr_wrap;
                    end
                    state_reg  <= ST_WAIT;
                end
                ST_WAIT: begin
                    irq_ack <= '0;
                    if (int_reply_q || timeout_hit) begin
                        interrupt <= 1'b0;
                        state_reg <= ST_END;
                    end
                end
                ST_END: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a fixed-priority and a round-robin instance,
// expected grants queued at stimulus time and popped when irq_ack fires.
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int BC = 16;

    typedef struct {
        logic [N-1:0]  ack;
        logic [CW-1:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]  irq_in_a, irq_en_a, irq_ack_a, pending_a;
    logic          gie_a, interrupt_a, int_reply_a, lost_a;
    logic [CW-1:0] cause_code_a;

    logic [N-1:0]  irq_in_b, irq_en_b, irq_ack_b, pending_b;
    logic          gie_b, interrupt_b, int_reply_b, lost_b;
    logic [CW-1:0] cause_code_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    irq_arbiter #(.NSRC(N), .CODE_W(CW), .BASE_CODE(BC), .RR(0), .TIMEOUT_CYC(8)) dut_a (
        .clk(clk), .rst(rst), .irq_in(irq_in_a), .irq_en(irq_en_a), .gie(gie_a),
        .irq_ack(irq_ack_a), .interrupt(interrupt_a), .int_reply(int_reply_a),
        .cause_code(cause_code_a), .pending(pending_a), .lost(lost_a)
    );

    irq_arbiter #(.NSRC(N), .CODE_W(CW), .BASE_CODE(BC), .RR(1), .TIMEOUT_CYC(8)) dut_b (
        .clk(clk), .rst(rst), .irq_in(irq_in_b), .irq_en(irq_en_b), .gie(gie_b),
        .irq_ack(irq_ack_b), .interrupt(interrupt_b), .int_reply(int_reply_b),
        .cause_code(cause_code_b), .pending(pending_b), .lost(lost_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int which, input int id);
        exp_t e;
        e.ack  = N'(1) << id;
        e.code = CW'(BC + id);
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    function automatic logic [N-1:0] ack_of(input int which);
        return (which == 0) ? irq_ack_a : irq_ack_b;
    endfunction

    function automatic logic int_of(input int which);
        return (which == 0) ? interrupt_a : interrupt_b;
    endfunction

    task automatic set_reply(input int which, input logic v);
        if (which == 0) int_reply_a = v;
        else            int_reply_b = v;
    endtask

    // Wait (bounded) for an ack pulse, then compare it against the queue head.
    task automatic wait_grant(input int which, input string tag);
        logic [N-1:0]  a;
        logic [CW-1:0] c;
        exp_t e;
        int n;
        n = 0;
        a = '0;
        while (n < 40) begin
            @(negedge clk);
            a = ack_of(which);
            if (a != '0) break;
            n++;
        end
        check({tag, "_seen"}, 32'(a != '0), 32'd1);
        c = (which == 0) ? cause_code_a : cause_code_b;
        if (which == 0) e = (q_a.size() > 0) ? q_a.pop_front() : '{'x, 'x};
        else            e = (q_b.size() > 0) ? q_b.pop_front() : '{'x, 'x};
        $display("grant %s: dut=%0d ack=%b code=%0d exp_ack=%b exp_code=%0d",
                 tag, which, a, c, e.ack, e.code);
        check({tag, "_ack"}, 32'(a), 32'(e.ack));
        check({tag, "_code"}, 32'(c), 32'(e.code));
        check({tag, "_int"}, 32'(int_of(which)), 32'd1);
    endtask

    task automatic serve(input int which, input string tag, input bit clear_src);
        int n;
        wait_grant(which, tag);
        if (clear_src) begin
            if (which == 0) irq_in_a = irq_in_a & ~irq_ack_a;
            else            irq_in_b = irq_in_b & ~irq_ack_b;
        end
        set_reply(which, 1'b1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(ack_of(which)), 32'd0);
        n = 0;
        while (int_of(which) !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drop"}, 32'(int_of(which)), 32'd0);
        set_reply(which, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        irq_in_a = 4'hF; irq_en_a = 4'hF; gie_a = 1'b1; int_reply_a = 1'b0;
        irq_in_b = 4'h0; irq_en_b = 4'hF; gie_b = 1'b1; int_reply_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_int_a", 32'(interrupt_a), 32'd0);
        check("rst_ack_a", 32'(irq_ack_a), 32'd0);
        check("rst_code_a", 32'(cause_code_a), 32'd0);
        check("rst_pend_a", 32'(pending_a), 32'd0);
        check("rst_lost_a", 32'(lost_a), 32'd0);
        check("rst_state_a", 32'(dut_a.state_reg), 32'(ST_IDLE));
        check("rst_int_b", 32'(interrupt_b), 32'd0);
        check("rst_code_b", 32'(cause_code_b), 32'd0);

        // Single source 2: exact latency and reply timing.
        rst = 1'b0;
        irq_in_a = 4'b0100;
        push_exp(0, 2);
        @(posedge clk); @(negedge clk);
        check("lat_pend", 32'(pending_a), 32'b0100);
        check("lat_e1_int", 32'(interrupt_a), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_e2_int", 32'(interrupt_a), 32'd0);
        @(posedge clk); @(negedge clk);
        begin
            exp_t e;
            e = q_a.pop_front();
            $display("grant lat: ack=%b code=%0d exp_ack=%b exp_code=%0d",
                     irq_ack_a, cause_code_a, e.ack, e.code);
            check("lat_e3_ack", 32'(irq_ack_a), 32'(e.ack));
            check("lat_e3_code", 32'(cause_code_a), 32'(e.code));
            check("lat_e3_int", 32'(interrupt_a), 32'd1);
        end
        int_reply_a = 1'b1;
        irq_in_a = 4'b0000;
        @(posedge clk); @(negedge clk);
        check("lat_e4_ack", 32'(irq_ack_a), 32'd0);
        check("lat_e4_int", 32'(interrupt_a), 32'd1);
        @(posedge clk); @(negedge clk);
        check("lat_e5_int", 32'(interrupt_a), 32'd0);
        check("lat_e5_code", 32'(cause_code_a), 32'd18);
        int_reply_a = 1'b0;
        repeat (3) @(negedge clk);

        // Two simultaneous requests under fixed priority.
        irq_in_a = 4'b1010;
        push_exp(0, 1);
        push_exp(0, 3);
        serve(0, "fp_first", 1'b1);
        serve(0, "fp_second", 1'b1);
        repeat (4) @(negedge clk);
        check("fp_idle_int", 32'(interrupt_a), 32'd0);

        // Round-robin rotation with all sources held.
        irq_in_b = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(1, k % N);
        for (int k = 0; k < 5; k++) serve(1, $sformatf("rr_%0d", k), 1'b0);
        irq_in_b = 4'b0000;

        // Global enable gating.
        gie_a = 1'b0;
        irq_in_a = 4'b0001;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("gie0_int", 32'(interrupt_a), 32'd0);
            check("gie0_pend", 32'(pending_a), 32'b0001);
        end
        gie_a = 1'b1;
        push_exp(0, 0);
        @(negedge clk);
        check("gie1_early", 32'(interrupt_a), 32'd0);
        wait_grant(0, "gie1");

        // Committed grant: source and gie drop in WAIT.
        irq_in_a = 4'b0000;
        gie_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("commit_int", 32'(interrupt_a), 32'd1);
        end
        int_reply_a = 1'b1;
        @(negedge clk);
        check("commit_hold", 32'(interrupt_a), 32'd1);
        @(negedge clk);
        check("commit_drop", 32'(interrupt_a), 32'd0);
        int_reply_a = 1'b0;
        gie_a = 1'b1;
        repeat (3) @(negedge clk);

        // Reply held high in IDLE blocks a new grant.
        int_reply_a = 1'b1;
        irq_in_a = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("replyblk_int", 32'(interrupt_a), 32'd0);
        end
        int_reply_a = 1'b0;
        push_exp(0, 1);
        serve(0, "replyblk", 1'b1);

        // Reset in the middle of WAIT loses the grant.
        irq_in_a = 4'b0100;
        push_exp(0, 2);
        wait_grant(0, "rstwait");
        @(negedge clk);
        rst = 1'b1;
        irq_in_a = 4'b0000;
        @(negedge clk);
        check("rstwait_int", 32'(interrupt_a), 32'd0);
        check("rstwait_ack", 32'(irq_ack_a), 32'd0);
        check("rstwait_state", 32'(dut_a.state_reg), 32'(ST_IDLE));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rstwait_quiet", 32'(interrupt_a), 32'd0);
        end

`ifdef IRQ_ARB_TIMEOUT_EN
        // Watchdog: no reply, interrupt held for 8 cycles then dropped.
        irq_in_a = 4'b0010;
        push_exp(0, 1);
        wait_grant(0, "to");
        irq_in_a = 4'b0000;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("to_hold", 32'(interrupt_a), 32'd1);
        end
        @(negedge clk);
        check("to_drop", 32'(interrupt_a), 32'd0);
        check("to_lost", 32'(lost_a), 32'd1);
        repeat (5) @(negedge clk);
        check("to_sticky", 32'(lost_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("to_clear", 32'(lost_a), 32'd0);
`else
        check("nolost_a", 32'(lost_a), 32'd0);
        check("nolost_b", 32'(lost_b), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Parametrised machine-level interrupt arbiter: the successor to the single-source eip/timer/software interrupt issue logic.
- Accepts NSRC level-sensitive interrupt sources with per-source enables and a global enable (mstatus.MIE).
- Selects one winner by fixed priority or round-robin, and delivers it to the CPU over the interrupt/int_reply handshake.
- Presents the winner's mcause code and the mip-style pending vector to the CSR file.

Parameters:
- NSRC, 4, number of interrupt sources (1..16).
- CODE_W, 5, width of cause_code.
- BASE_CODE, 16, cause code of source 0; source i reports BASE_CODE+i.
- RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYC, 1024, reply watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- irq_in  in  NSRC  level interrupt requests.
- irq_en  in  NSRC  per-source enable (mie bits).
- gie  in  1  global interrupt enable (mstatus.MIE).
- irq_ack  out  NSRC  one-cycle grant pulse to the winning source.
- interrupt  out  1  held high until CPU reply.
- int_reply  in  1  CPU acknowledge (level).
- cause_code  out  CODE_W  winner's cause code, valid while interrupt=1.
- pending  out  NSRC  registered irq_in, for the mip read view.
- lost  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset: state=IDLE; interrupt, irq_ack, cause_code, pending, lost, RR pointer and all input registers = 0.
- Inputs are registered once: pending<=irq_in; int_reply_q<=int_reply.
- Candidate vector cand = pending & irq_en, qualified by gie.
- IDLE: if gie && |cand, latch winner id and go to ISSUE.
  - Fixed priority (RR=0): lowest set index wins.
  - Round-robin (RR=1): first set index at or above ptr, wrapping modulo NSRC.
- ISSUE (1 cycle): interrupt<=1; irq_ack[id]<=1 for exactly one cycle; cause_code<=BASE_CODE+id, truncated to CODE_W. If RR=1, ptr<=(id+1) mod NSRC. Then go to WAIT.
- WAIT: irq_ack<=0. When int_reply_q=1: interrupt<=0, cause_code holds, go to END.
- END (1 guard cycle): go to IDLE. No new grant is possible until int_reply has been sampled low for one cycle: IDLE additionally requires int_reply_q=0.
- Latency: irq_in rises at edge k; pending at k+1; ISSUE at k+2; interrupt and irq_ack visible after edge k+3.
- Once latched, a grant is committed. Source drop, irq_en clear or gie drop during ISSUE/WAIT does not cancel delivery.
- Simultaneous requests: exactly one winner per grant. Losers stay pending and are granted in later rounds.
- NSRC=1: ptr is constant 0.
- int_reply outside WAIT is ignored.
- rst mid-handshake: return to IDLE, drop interrupt, lose the grant. Sources must re-request.

Optional Feature:
- Macro: IRQ_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT and clears on entry. On reaching TIMEOUT_CYC-1 without int_reply_q: interrupt<=0, lost<=1 (sticky until rst), go to END.
- Undefined: no counter; WAIT is unbounded; lost=0.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/WAIT/END), cause code constants (machine software 3, timer 7, external 11, BASE_CODE default 16).
- One sub-module, irq_pick: combinational winner select with fixed/RR mode; inputs cand and ptr; outputs id and valid. Reused by later multi-hart arbitration.

Test Plan:
- NSRC=4, RR=0, irq_en=4'hF, gie=1; irq_in=4'b0100 at edge 0 -> interrupt=1 and irq_ack=4'b0100 after edge 3; cause_code=18; int_reply held -> interrupt=0 two edges later.
- irq_in=4'b1010, RR=0 -> first grant id1 (code 17); reply; second grant id3 (code 19).
- RR=1, irq_in=4'b1111 held, CPU replies each grant -> grant order 0,1,2,3,0.
- gie=0 with irq_in=4'b0001 -> no interrupt for 20 cycles. gie=1 -> interrupt 2 cycles later; pending=4'b0001 throughout.
- Grant issued, then irq_in and gie dropped in WAIT -> interrupt stays high until int_reply; rst in WAIT -> interrupt=0 next edge, state IDLE.
- IRQ_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no reply -> interrupt drops 8 cycles into WAIT; lost=1 and stays 1 until rst.
